// File: rtl/alu_cmd_issuer.sv
// Queues ALU commands and presents them one at a time, then waits one settle cycle and checks for overflow.
// Define ALU_CMD_FIFO_EN for a DEPTH-entry command FIFO; otherwise a single holding register is used.
module alu_cmd_issuer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [1:0]       cmd_mode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [2:0]       in_selector,
    output logic [6:0]       out_selector,
    output logic [WIDTH-1:0] num1,
    output logic [WIDTH-1:0] num2,
    output logic             issue,
    input  logic             alu_overflow,
    input  logic             err_clr,
    output logic             err,
    output logic             busy,
    output logic             cmd_drop
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SETTLE, S_ERR} state_t;

    state_t           state_q;
    logic             push;
    logic             pop;
    logic             head_vld;
    logic [2:0]       head_op;
    logic [1:0]       head_mode;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;

    logic             issue_q, err_q, busy_q, drop_q;
    logic [2:0]       in_sel_q;
    logic [6:0]       out_sel_q;
    logic [WIDTH-1:0] num1_q, num2_q;

    function automatic logic [2:0] mode_sel(input logic [1:0] mode);
        case (mode)
            2'd1:    return 3'b010;
            2'd2:    return 3'b001;
            default: return 3'b100;
        endcase
    endfunction

    assign push = cmd_valid && cmd_ready;
    // Illegal ops are popped too, so the queue never stalls behind them.
    assign pop  = (state_q == S_IDLE) && head_vld;

`ifdef ALU_CMD_FIFO_EN
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [2:0]       op_mem   [DEPTH];
    logic [1:0]       mode_mem [DEPTH];
    logic [WIDTH-1:0] a_mem    [DEPTH];
    logic [WIDTH-1:0] b_mem    [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;

    assign cmd_ready = (count_q < CW'(DEPTH));
    assign head_vld  = (count_q != '0);
    assign head_op   = op_mem[rd_ptr_q];
    assign head_mode = mode_mem[rd_ptr_q];
    assign head_a    = a_mem[rd_ptr_q];
    assign head_b    = b_mem[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr_q]   <= cmd_op;
            mode_mem[wr_ptr_q] <= cmd_mode;
            a_mem[wr_ptr_q]    <= cmd_a;
            b_mem[wr_ptr_q]    <= cmd_b;
        end
    end
`else
    logic             hold_vld_q;
    logic [2:0]       hold_op_q;
    logic [1:0]       hold_mode_q;
    logic [WIDTH-1:0] hold_a_q, hold_b_q;

    assign cmd_ready = !hold_vld_q;
    assign head_vld  = hold_vld_q;
    assign head_op   = hold_op_q;
    assign head_mode = hold_mode_q;
    assign head_a    = hold_a_q;
    assign head_b    = hold_b_q;

    always_ff @(posedge clk) begin
        if (rst)       hold_vld_q <= 1'b0;
        else if (push) hold_vld_q <= 1'b1;
        else if (pop)  hold_vld_q <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            hold_op_q   <= cmd_op;
            hold_mode_q <= cmd_mode;
            hold_a_q    <= cmd_a;
            hold_b_q    <= cmd_b;
        end
    end
`endif

    // Outputs are loaded on the edge entering each state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            issue_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            drop_q    <= 1'b0;
            in_sel_q  <= 3'b100;
            out_sel_q <= '0;
            num1_q    <= '0;
            num2_q    <= '0;
        end else begin
            issue_q  <= 1'b0;
            drop_q   <= 1'b0;
            in_sel_q <= 3'b100;
            case (state_q)
                S_IDLE: begin
                    if (head_vld) begin
                        if (head_op == 3'd7) begin
                            drop_q <= 1'b1;
                        end else begin
                            state_q   <= S_ISSUE;
                            issue_q   <= 1'b1;
                            busy_q    <= 1'b1;
                            in_sel_q  <= mode_sel(head_mode);
                            out_sel_q <= 7'(1) << head_op;
                            num1_q    <= head_a;
                            num2_q    <= head_b;
                        end
                    end
                end
                S_ISSUE: begin
                    state_q <= S_SETTLE;
                end
                S_SETTLE: begin
                    busy_q <= 1'b0;
                    if (alu_overflow) begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ERR: begin
                    if (err_clr) begin
                        state_q <= S_IDLE;
                        err_q   <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign issue        = issue_q;
    assign err          = err_q;
    assign busy         = busy_q;
    assign cmd_drop     = drop_q;
    assign in_selector  = in_sel_q;
    assign out_selector = out_sel_q;
    assign num1         = num1_q;
    assign num2         = num2_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer; expectations adapt to whether ALU_CMD_FIFO_EN is defined.
module tb_alu_cmd_issuer;

`ifdef ALU_CMD_FIFO_EN
    localparam bit FIFO = 1'b1;
`else
    localparam bit FIFO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [1:0] cmd_mode;
    logic [7:0] cmd_a, cmd_b;
    logic [2:0] in_selector;
    logic [6:0] out_selector;
    logic [7:0] num1, num2;
    logic       issue;
    logic       alu_overflow;
    logic       err_clr;
    logic       err, busy, cmd_drop;

    int n_chk  = 0;
    int n_fail = 0;
    logic [25:0] issued [$];

    alu_cmd_issuer #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_mode(cmd_mode), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .in_selector(in_selector), .out_selector(out_selector),
        .num1(num1), .num2(num2), .issue(issue), .alu_overflow(alu_overflow),
        .err_clr(err_clr), .err(err), .busy(busy), .cmd_drop(cmd_drop)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (issue === 1'b1) issued.push_back({in_selector, out_selector, num1, num2});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_wait(input logic [2:0] op, input logic [1:0] mode,
                             input logic [7:0] a, input logic [7:0] b);
        int g;
        g = 0;
        cmd_op = op; cmd_mode = mode; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && g < 40) begin
            tick();
            g++;
        end
        chk("push_ready_wait", 32'(cmd_ready), 32'h1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_sel"},  32'(in_selector),  32'h4);
        chk({tag, "_out_sel"}, 32'(out_selector), 32'h0);
        chk({tag, "_num1"},    32'(num1),         32'h0);
        chk({tag, "_num2"},    32'(num2),         32'h0);
        chk({tag, "_issue"},   32'(issue),        32'h0);
        chk({tag, "_err"},     32'(err),          32'h0);
        chk({tag, "_busy"},    32'(busy),         32'h0);
        chk({tag, "_drop"},    32'(cmd_drop),     32'h0);
        chk({tag, "_ready"},   32'(cmd_ready),    32'h1);
    endtask

`ifdef ALU_CMD_FIFO_EN
    task automatic enter_err();
        int g;
        g = 0;
        push_wait(3'd6, 2'd0, 8'hFF, 8'h02);
        while (issue !== 1'b1 && g < 20) begin
            tick();
            g++;
        end
        chk("enter_err_issue", 32'(issue), 32'h1);
        alu_overflow = 1'b1;
        tick();
        tick();
        alu_overflow = 1'b0;
        chk("enter_err_err", 32'(err), 32'h1);
    endtask
`endif

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_mode = '0; cmd_a = '0; cmd_b = '0;
        alu_overflow = 1'b0; err_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk_reset_outputs("reset");

        // Basic ADD/load command
        push_wait(3'd4, 2'd1, 8'h12, 8'h05);
        chk("add_ready_after_push", 32'(cmd_ready), FIFO ? 32'h1 : 32'h0);
        chk("add_no_issue_yet", 32'(issue), 32'h0);
        tick();
        chk("add_issue",   32'(issue),        32'h1);
        chk("add_in_sel",  32'(in_selector),  32'h2);
        chk("add_out_sel", 32'(out_selector), 32'h10);
        chk("add_num1",    32'(num1),         32'h12);
        chk("add_num2",    32'(num2),         32'h05);
        chk("add_busy",    32'(busy),         32'h1);
        chk("add_ready_after_pop", 32'(cmd_ready), 32'h1);
        tick();
        chk("add_settle_issue",  32'(issue),        32'h0);
        chk("add_settle_busy",   32'(busy),         32'h1);
        chk("add_settle_in_sel", 32'(in_selector),  32'h4);
        chk("add_hold_out_sel",  32'(out_selector), 32'h10);
        chk("add_hold_num1",     32'(num1),         32'h12);
        tick();
        chk("add_idle_busy", 32'(busy), 32'h0);
        chk("add_idle_err",  32'(err),  32'h0);

        // Illegal op dropped, following AND issued
        push_wait(3'd7, 2'd0, 8'hAA, 8'h55);
        tick();
        chk("drop_pulse",      32'(cmd_drop),     32'h1);
        chk("drop_no_issue",   32'(issue),        32'h0);
        chk("drop_hold_osel",  32'(out_selector), 32'h10);
        chk("drop_busy",       32'(busy),         32'h0);
        tick();
        chk("drop_pulse_end",  32'(cmd_drop),     32'h0);
        chk("drop_still_none", 32'(issue),        32'h0);
        push_wait(3'd0, 2'd2, 8'h0F, 8'hF0);
        tick();
        chk("and_issue",   32'(issue),        32'h1);
        chk("and_out_sel", 32'(out_selector), 32'h01);
        chk("and_in_sel",  32'(in_selector),  32'h1);
        chk("and_num1",    32'(num1),         32'h0F);
        chk("and_num2",    32'(num2),         32'hF0);
        tick();
        tick();

        // MULT with overflow -> ERR, queued XOR waits for err_clr
        push_wait(3'd6, 2'd0, 8'hFF, 8'h02);
        tick();
        chk("mult_issue",   32'(issue),        32'h1);
        chk("mult_out_sel", 32'(out_selector), 32'h40);
        chk("mult_in_sel",  32'(in_selector),  32'h4);
        alu_overflow = 1'b1;
        tick();
        chk("mult_settle_busy", 32'(busy), 32'h1);
        tick();
        alu_overflow = 1'b0;
        chk("mult_err",      32'(err),  32'h1);
        chk("mult_err_busy", 32'(busy), 32'h0);
        push_wait(3'd3, 2'd3, 8'h3C, 8'h0F);
        tick();
        tick();
        chk("err_no_issue", 32'(issue), 32'h0);
        chk("err_held",     32'(err),   32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_cleared", 32'(err),   32'h0);
        chk("err_clr_no_issue", 32'(issue), 32'h0);
        tick();
        chk("xor_issue",   32'(issue),        32'h1);
        chk("xor_out_sel", 32'(out_selector), 32'h08);
        chk("xor_in_sel",  32'(in_selector),  32'h4);
        chk("xor_num1",    32'(num1),         32'h3C);
        chk("xor_num2",    32'(num2),         32'h0F);
        tick();
        tick();

        // Back-to-back pushes, order preserved
        issued.delete();
        push_wait(3'd1, 2'd1, 8'h11, 8'hA1);
        chk("b2b_ready_after_first", 32'(cmd_ready), FIFO ? 32'h1 : 32'h0);
        push_wait(3'd3, 2'd2, 8'h22, 8'hB2);
        push_wait(3'd5, 2'd0, 8'h33, 8'hC3);
        push_wait(3'd4, 2'd3, 8'h44, 8'hD4);
        repeat (20) tick();
        chk("b2b_count", 32'(issued.size()), 32'h4);
        if (issued.size() == 4) begin
            chk("b2b_0", 32'(issued[0]), 32'({3'b010, 7'b0000010, 8'h11, 8'hA1}));
            chk("b2b_1", 32'(issued[1]), 32'({3'b001, 7'b0001000, 8'h22, 8'hB2}));
            chk("b2b_2", 32'(issued[2]), 32'({3'b100, 7'b0100000, 8'h33, 8'hC3}));
            chk("b2b_3", 32'(issued[3]), 32'({3'b100, 7'b0010000, 8'h44, 8'hD4}));
        end

`ifdef ALU_CMD_FIFO_EN
        // Fill FIFO while in ERR, fifth command held until err_clr
        enter_err();
        issued.delete();
        push_wait(3'd1, 2'd1, 8'h01, 8'h10);
        push_wait(3'd3, 2'd2, 8'h02, 8'h20);
        push_wait(3'd4, 2'd0, 8'h03, 8'h30);
        push_wait(3'd5, 2'd3, 8'h04, 8'h40);
        chk("full_ready", 32'(cmd_ready), 32'h0);
        cmd_op = 3'd0; cmd_mode = 2'd1; cmd_a = 8'h05; cmd_b = 8'h50; cmd_valid = 1'b1;
        tick();
        tick();
        chk("full_ready_held", 32'(cmd_ready), 32'h0);
        chk("full_no_issue",   32'(issue),     32'h0);
        chk("full_err",        32'(err),       32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("full_err_cleared", 32'(err), 32'h0);
        push_wait(3'd0, 2'd1, 8'h05, 8'h50);
        repeat (25) tick();
        chk("full_count", 32'(issued.size()), 32'h5);
        if (issued.size() == 5) begin
            chk("full_0", 32'(issued[0]), 32'({3'b010, 7'b0000010, 8'h01, 8'h10}));
            chk("full_1", 32'(issued[1]), 32'({3'b001, 7'b0001000, 8'h02, 8'h20}));
            chk("full_2", 32'(issued[2]), 32'({3'b100, 7'b0010000, 8'h03, 8'h30}));
            chk("full_3", 32'(issued[3]), 32'({3'b100, 7'b0100000, 8'h04, 8'h40}));
            chk("full_4", 32'(issued[4]), 32'({3'b010, 7'b0000001, 8'h05, 8'h50}));
        end

        // Reset during SETTLE with three commands still queued
        enter_err();
        push_wait(3'd0, 2'd0, 8'h61, 8'h16);
        push_wait(3'd1, 2'd0, 8'h62, 8'h26);
        push_wait(3'd3, 2'd0, 8'h63, 8'h36);
        push_wait(3'd4, 2'd0, 8'h64, 8'h46);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
        chk("rst_pre_issue", 32'(issue), 32'h1);
        tick();
        chk("rst_pre_settle_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outputs("rst_settle");
`else
        // Reset during SETTLE with the holding register occupied
        push_wait(3'd0, 2'd0, 8'h61, 8'h16);
        tick();
        chk("rst_pre_issue", 32'(issue), 32'h1);
        push_wait(3'd1, 2'd0, 8'h62, 8'h26);
        chk("rst_pre_settle_busy", 32'(busy), 32'h1);
        chk("rst_pre_held", 32'(cmd_ready), 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outputs("rst_settle");
`endif
        issued.delete();
        repeat (15) tick();
        chk("rst_no_later_issue", 32'(issued.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-007 SHALL have port cmd_op  input  3  0=AND, 1=OR, 2=NOT, 3=XOR, 4=ADD, 5=SUB, 6=MULT, 7=illegal.
REQ-008 SHALL have port cmd_mode  input  2  accumulator input select: 0=persist, 1=load, 2=reset, 3=persist.
REQ-009 SHALL have port cmd_a  input  WIDTH  value driven on num1.
REQ-010 SHALL have port cmd_b  input  WIDTH  value driven on num2.
REQ-011 SHALL have port in_selector  output  3  one-hot to ALU: bit2 persist, bit1 load, bit0 reset.
REQ-012 SHALL have port out_selector  output  7  one-hot to ALU: bit0 AND ... bit6 MULT (bit n = op n).
REQ-013 SHALL have ports num1, num2  output  WIDTH  operands to ALU.
REQ-014 SHALL have port issue  output  1  high for the single cycle a command is presented.
REQ-015 SHALL have port alu_overflow  input  1  ALU overflow flag.
REQ-016 SHALL have port err_clr  input  1  clears error state.
REQ-017 SHALL have ports err, busy, cmd_drop  output  1 each  error state, command in flight, illegal-op dropped pulse.

Function
REQ-018 SHALL implement states IDLE, ISSUE, SETTLE, ERR; all outputs registered.
REQ-019 IDLE: if FIFO non-empty, pop head; legal op -> ISSUE next cycle; op 7 -> cmd_drop=1 for one cycle, stay IDLE.
REQ-020 ISSUE: for exactly one cycle, issue=1, in_selector per cmd_mode, out_selector one-hot of cmd_op, num1=cmd_a, num2=cmd_b; next SETTLE.
REQ-021 SETTLE: one cycle; if alu_overflow=1 -> ERR, else -> IDLE.
REQ-022 ERR: err=1, no pops; on err_clr=1 -> IDLE with err=0 next cycle; err_clr ignored in other states.
REQ-023 Outside ISSUE, in_selector SHALL be 3'b100 (persist); out_selector, num1, num2 hold last issued values.
REQ-024 busy SHALL be 1 in ISSUE and SETTLE, else 0; command latency push-to-issue minimum 2 cycles from empty.
REQ-025 cmd_ready SHALL equal (FIFO count < DEPTH) from registered count; a pop in the same cycle does not raise ready.
REQ-026 Push and pop in the same cycle SHALL leave count unchanged; pointers wrap modulo DEPTH; pop when empty never occurs.
REQ-027 FIFO SHALL keep accepting commands in ERR until full.
REQ-028 Command order SHALL be strictly FIFO; no command lost or duplicated except op 7 drops.

Reset
REQ-029 rst=1 at a clock edge SHALL set state IDLE, FIFO count and pointers 0, in_selector 3'b100, out_selector 0, num1=num2=0, issue=err=busy=cmd_drop=0, cmd_ready=1 next cycle.
REQ-030 rst SHALL override all other inputs, including mid-ISSUE/SETTLE/ERR; in-flight and queued commands discarded.

Configuration
REQ-031 Macro ALU_CMD_FIFO_EN defined: DEPTH-entry FIFO as above.
REQ-032 ALU_CMD_FIFO_EN undefined: single holding register replaces FIFO, DEPTH ignored, cmd_ready = !holding_valid, holding register freed on pop; all other behaviour identical.

Verification
REQ-033 After rst, push {op=4, mode=1, a=8'h12, b=8'h05} -> issue=1 two cycles later, in_selector=3'b010, out_selector=7'b0010000, num1=8'h12, num2=8'h05, then busy 0 after SETTLE.
REQ-034 Push 4 commands with no pops possible (hold in ERR) -> cmd_ready=0 after 4th accept (FIFO build); 5th held until err_clr, then issued in order.
REQ-035 op=6, alu_overflow=1 during SETTLE -> err=1, no further issue; err_clr pulse -> err=0, next queued command issued.
REQ-036 Push op=7 then op=0 -> cmd_drop one-cycle pulse, no issue for op 7; op 0 issued with out_selector=7'b0000001.
REQ-037 Assert rst during SETTLE with 3 queued -> all outputs at reset values next cycle, cmd_ready=1, no later issue without new pushes.
REQ-038 Back-to-back pushes every cycle with ALU_CMD_FIFO_EN undefined -> cmd_ready toggles, every accepted command issued exactly once in order.
